// File: rtl/rns2bin_32_31_21_5.sv
// rns2bin_32_31_21_5: mixed-radix RNS(32,31,21,5) to binary converter, one radix step per clock
module rns2bin_32_31_21_5 #(
    parameter int MAX_MOD  = 5,
    parameter int OUT_SIZE = 17
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MAX_MOD-1:0]  in_mod_1,
    input  logic [MAX_MOD-1:0]  in_mod_2,
    input  logic [MAX_MOD-1:0]  in_mod_3,
    input  logic [MAX_MOD-1:0]  in_mod_4,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_SIZE-1:0] out_data,
    output logic                out_err
);
    typedef enum logic [2:0] {IDLE, STEP2, STEP3, STEP4, DONE} state_t;
    localparam logic [OUT_SIZE-1:0] M2 = OUT_SIZE'(31);
    localparam logic [OUT_SIZE-1:0] M3 = OUT_SIZE'(21);
    localparam logic [OUT_SIZE-1:0] M4 = OUT_SIZE'(5);
    localparam logic [OUT_SIZE-1:0] W2 = OUT_SIZE'(32);
    localparam logic [OUT_SIZE-1:0] W3 = OUT_SIZE'(992);
    localparam logic [OUT_SIZE-1:0] W4 = OUT_SIZE'(20832);
    localparam logic [OUT_SIZE-1:0] I3 = OUT_SIZE'(17);
    localparam logic [OUT_SIZE-1:0] I4 = OUT_SIZE'(3);
    state_t state_q, state_d;
    logic [MAX_MOD-1:0]  r2_q, r2_d, r3_q, r3_d, r4_q, r4_d;
    logic [OUT_SIZE-1:0] x_q, x_d, out_data_q, out_data_d, a2, a3, a4;
    logic                err_q, err_d, out_err_q, out_err_d;
    // Mixed-radix digits; adding the modulus first keeps each difference non-negative
    assign a2 = (OUT_SIZE'(r2_q) + M2 - x_q % M2) % M2;
    assign a3 = ((OUT_SIZE'(r3_q) + M3 - x_q % M3) * I3) % M3;
    assign a4 = ((OUT_SIZE'(r4_q) + M4 - x_q % M4) * I4) % M4;
    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end
    // Next state: accept in IDLE, step through the radices, hold DONE until consumed
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid ? STEP2 : IDLE;
            STEP2:   state_d = STEP3;
            STEP3:   state_d = STEP4;
            STEP4:   state_d = DONE;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    // Handshake outputs are pure state decodes
    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
    end
    // Datapath next state: capture residues on accept, accumulate one radix term per step
    always_comb begin
        r2_d       = r2_q;
        r3_d       = r3_q;
        r4_d       = r4_q;
        x_d        = x_q;
        err_d      = err_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        case (state_q)
            IDLE: if (in_valid) begin
                r2_d  = in_mod_2;
                r3_d  = in_mod_3;
                r4_d  = in_mod_4;
                x_d   = OUT_SIZE'(in_mod_1);
                err_d = (in_mod_2 > MAX_MOD'(30)) || (in_mod_3 > MAX_MOD'(20)) || (in_mod_4 > MAX_MOD'(4));
            end
            STEP2: x_d = x_q + W2 * a2;
            STEP3: x_d = x_q + W3 * a3;
            STEP4: begin
                out_data_d = err_q ? '0 : x_q + W4 * a4;
                out_err_d  = err_q;
            end
            default: ;
        endcase
    end
    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r2_q       <= '0;
            r3_q       <= '0;
            r4_q       <= '0;
            x_q        <= '0;
            err_q      <= 1'b0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            r2_q       <= r2_d;
            r3_q       <= r3_d;
            r4_q       <= r4_d;
            x_q        <= x_d;
            err_q      <= err_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end
    assign out_data = out_data_q;
    assign out_err  = out_err_q;
endmodule

// File: tb/tb_rns2bin_32_31_21_5.sv
// tb_rns2bin_32_31_21_5: random and directed checks of the RNS-to-binary converter against a CRT search model
module tb_rns2bin_32_31_21_5;
    logic        clk, reset, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [4:0]  in_mod_1, in_mod_2, in_mod_3, in_mod_4;
    logic [16:0] out_data;
    int          n_pass, n_total, mode, cyc, acc_cyc;
    bit          pend;
    logic [16:0] exp_d;
    logic        exp_e;
    wire         exp_v = pend && (cyc - acc_cyc >= 4);

    rns2bin_32_31_21_5 dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mod_1(in_mod_1), .in_mod_2(in_mod_2), .in_mod_3(in_mod_3), .in_mod_4(in_mod_4),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the unique X < 104160 with the given residues, found by search; {err, X}
    function automatic logic [17:0] model(input int a, input int b, input int c, input int d);
        if (b > 30 || c > 20 || d > 4) return {1'b1, 17'd0};
        for (int k = 0; k < 3255; k++) begin
            int x;
            x = a + 32 * k;
            if (x % 31 == b && x % 21 == c && x % 5 == d) return {1'b0, 17'(x)};
        end
        return '1;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    endtask

    // Transaction model: one tuple in flight, result visible 4 cycles after accept until consumed
    always @(posedge clk or posedge reset) begin
        if (reset) pend <= 1'b0;
        else begin
            cyc <= cyc + 1;
            if (!pend && in_valid) begin
                pend    <= 1'b1;
                acc_cyc <= cyc;
                {exp_e, exp_d} <= model(int'(in_mod_1), int'(in_mod_2), int'(in_mod_3), int'(in_mod_4));
            end else if (pend && cyc - acc_cyc >= 4 && out_ready) pend <= 1'b0;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("in_ready", int'(in_ready), int'(!pend));
        chk("out_valid", int'(out_valid), int'(exp_v));
        if (exp_v) begin
            chk("out_data", int'(out_data), int'(exp_d));
            chk("out_err", int'(out_err), int'(exp_e));
        end
    end

    // Consumer: random, always ready, or stalled
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            out_ready = mode == 2 ? 1'b0 : mode == 1 ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input int a, input int b, input int c, input int d);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_ready_timeout", int'(in_ready), 1);
        in_mod_1 = 5'(a);
        in_mod_2 = 5'(b);
        in_mod_3 = 5'(c);
        in_mod_4 = 5'(d);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_mod_1 = 5'($urandom);
        in_mod_2 = 5'($urandom);
        in_mod_3 = 5'($urandom);
        in_mod_4 = 5'($urandom);
    endtask

    task automatic wait_out(input string nm, input int d, input int e);
        int n;
        n = 0;
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_data"}, int'(out_data), d);
        chk({nm, "_err"}, int'(out_err), e);
    endtask

    initial begin
        n_pass = 0; n_total = 0; mode = 1; cyc = 0; acc_cyc = 0;
        in_valid = 1'b0;
        in_mod_1 = '0; in_mod_2 = '0; in_mod_3 = '0; in_mod_4 = '0;
        reset = 1'b1;
        chk("model_100000", int'(model(0, 25, 19, 0)), 100000);
        chk("model_65535", int'(model(31, 1, 15, 0)), 65535);
        chk("model_104159", int'(model(31, 30, 20, 4)), 104159);
        chk("model_err", int'(model(0, 31, 0, 0)), 1 << 17);
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_err", int'(out_err), 0);
        reset = 1'b0;
        send(0, 25, 19, 0);  wait_out("d100000", 100000, 0);
        send(31, 1, 15, 0);  wait_out("d65535", 65535, 0);
        send(0, 0, 0, 0);    wait_out("d0", 0, 0);
        send(31, 30, 20, 4); wait_out("dmax", 104159, 0);
        send(0, 31, 0, 0);   wait_out("err_r2", 0, 1);
        send(0, 0, 0, 5);    wait_out("err_r4", 0, 1);
        // Stall the consumer for 10 DONE cycles, then release
        mode = 2;
        send(31, 1, 15, 0);
        wait_out("stall_first", 65535, 0);
        repeat (10) begin
            @(negedge clk);
            chk("stall_data", int'(out_data), 65535);
            chk("stall_in_ready", int'(in_ready), 0);
        end
        mode = 1;
        repeat (3) @(negedge clk);
        chk("release_in_ready", int'(in_ready), 1);
        // Reset pulse while in STEP3 aborts the conversion
        send(12, 7, 3, 2);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_out_data", int'(out_data), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        send(0, 25, 19, 0);  wait_out("after_abort", 100000, 0);
        // Randomized traffic with a random consumer
        mode = 0;
        for (int t = 0; t < 250; t++) begin
            int x, sel;
            x = int'($urandom_range(0, 104159));
            sel = int'($urandom_range(0, 9));
            if (sel == 0) send(x % 32, 31, x % 21, x % 5);
            else if (sel == 1) send(x % 32, x % 31, int'($urandom_range(21, 31)), x % 5);
            else if (sel == 2) send(x % 32, x % 31, x % 21, int'($urandom_range(5, 31)));
            else send(x % 32, x % 31, x % 21, x % 5);
            repeat (int'($urandom_range(0, 2))) @(negedge clk);
        end
        mode = 1;
        for (int n = 0; n < 40 && pend; n++) @(negedge clk);
        if (pend) chk("drain_timeout", int'(pend), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
